// File: rtl/wb_arb2.sv
`default_nettype none
// ============================================================================
// Module      : wb_arb2
// Description : Two-master Wishbone arbiter in front of one shared slave.
//               Round-robin on simultaneous requests, no pre-emption while
//               the granted master holds cyc, registered one-hot grant.
//               Optional stall watchdog enabled by macro WB_ARB2_TIMEOUT_EN:
//               aborts a stalled strobe with err after TIMEOUT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arb2 #(
    parameter int TIMEOUT = 255,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic            clk,
    input  logic            rst,
    // master 0 (dat_o = write data from master, dat_i = read data to master)
    input  logic            m0_cyc,
    input  logic            m0_stb,
    input  logic            m0_we,
    input  logic [AW-1:0]   m0_adr,
    input  logic [DW-1:0]   m0_dat_o,
    input  logic [DW/8-1:0] m0_sel,
    output logic            m0_ack,
    output logic            m0_err,
    output logic            m0_rty,
    output logic [DW-1:0]   m0_dat_i,
    // master 1
    input  logic            m1_cyc,
    input  logic            m1_stb,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_adr,
    input  logic [DW-1:0]   m1_dat_o,
    input  logic [DW/8-1:0] m1_sel,
    output logic            m1_ack,
    output logic            m1_err,
    output logic            m1_rty,
    output logic [DW-1:0]   m1_dat_i,
    // shared slave
    output logic            s_cyc,
    output logic            s_stb,
    output logic            s_we,
    output logic [AW-1:0]   s_adr,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel,
    input  logic            s_ack,
    input  logic            s_err,
    input  logic            s_rty,
    input  logic [DW-1:0]   s_dat_i,
    // current grant, bit0 = m0, bit1 = m1
    output logic [1:0]      gnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;
    logic   last;       // master granted most recently (1 = m1)
    logic   last_nx;
    logic   stb_raw;    // strobe of the granted master before watchdog gating
    logic   tmo_hit;    // watchdog abort this cycle

    // TIMEOUT must fit the 8-bit stall counter and be non-zero
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("wb_arb2: TIMEOUT must be in 1..255");
    end

    // State, round-robin pointer and registered grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
            gnt   <= 2'b00;
        end else begin
            state <= state_nx;
            last  <= last_nx;
            gnt   <= {state_nx == GNT1, state_nx == GNT0};
        end
    end

    // Next-state: grant on request, hold while cyc, hand over directly
    always_comb begin
        state_nx = state;
        last_nx  = last;
        case (state)
            IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    state_nx = last ? GNT0 : GNT1;
                end else if (m0_cyc) begin
                    state_nx = GNT0;
                end else if (m1_cyc) begin
                    state_nx = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc) begin
                    last_nx  = 1'b0;
                    state_nx = m1_cyc ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc) begin
                    last_nx  = 1'b1;
                    state_nx = m0_cyc ? GNT0 : IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Forward the granted master's request to the slave; idle drives nothing
    always_comb begin
        s_cyc   = 1'b0;
        stb_raw = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_o = '0;
        s_sel   = '0;
        case (state)
            GNT0: begin
                s_cyc   = m0_cyc;
                stb_raw = m0_stb;
                s_we    = m0_we;
                s_adr   = m0_adr;
                s_dat_o = m0_dat_o;
                s_sel   = m0_sel;
            end
            GNT1: begin
                s_cyc   = m1_cyc;
                stb_raw = m1_stb;
                s_we    = m1_we;
                s_adr   = m1_adr;
                s_dat_o = m1_dat_o;
                s_sel   = m1_sel;
            end
            default: begin
                s_cyc   = 1'b0;
            end
        endcase
    end

    // A watchdog abort withdraws the strobe so the slave sees no access
    assign s_stb = stb_raw & ~tmo_hit;

    // Return slave responses to the granted master only; idle drops them
    always_comb begin
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m0_rty   = 1'b0;
        m0_dat_i = '0;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        m1_rty   = 1'b0;
        m1_dat_i = '0;
        case (state)
            GNT0: begin
                m0_ack   = s_ack;
                m0_err   = s_err | tmo_hit;
                m0_rty   = s_rty;
                m0_dat_i = s_dat_i;
            end
            GNT1: begin
                m1_ack   = s_ack;
                m1_err   = s_err | tmo_hit;
                m1_rty   = s_rty;
                m1_dat_i = s_dat_i;
            end
            default: begin
                m0_ack   = 1'b0;
            end
        endcase
    end

`ifdef WB_ARB2_TIMEOUT_EN
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    logic [7:0] cnt;    // consecutive cycles of unanswered strobe
    logic       cnt_clr;

    assign tmo_hit = (state != IDLE) && (cnt == TMO);
    assign cnt_clr = tmo_hit || !stb_raw || s_ack || s_err || s_rty ||
                     (state_nx != state);

    // Stall counter: runs while strobe is unanswered on a stable grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (cnt_clr) begin
            cnt <= 8'd0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_arb2.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arb2
// Description : Directed self-checking bench for wb_arb2 (single read,
//               round-robin tie, burst atomicity, idle ack, async reset,
//               stall behaviour with and without WB_ARB2_TIMEOUT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arb2;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc, m0_stb, m0_we;
    logic [31:0] m0_adr, m0_dat_o;
    logic [3:0]  m0_sel;
    logic        m0_ack, m0_err, m0_rty;
    logic [31:0] m0_dat_i;
    logic        m1_cyc, m1_stb, m1_we;
    logic [31:0] m1_adr, m1_dat_o;
    logic [3:0]  m1_sel;
    logic        m1_ack, m1_err, m1_rty;
    logic [31:0] m1_dat_i;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr, s_dat_o;
    logic [3:0]  s_sel;
    logic        s_ack, s_err, s_rty;
    logic [31:0] s_dat_i;
    logic [1:0]  gnt;

    int n_checks = 0;
    int n_errors = 0;

    wb_arb2 #(.TIMEOUT(16), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_dat_o(m0_dat_o), .m0_sel(m0_sel), .m0_ack(m0_ack), .m0_err(m0_err),
        .m0_rty(m0_rty), .m0_dat_i(m0_dat_i),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_dat_o(m1_dat_o), .m1_sel(m1_sel), .m1_ack(m1_ack), .m1_err(m1_err),
        .m1_rty(m1_rty), .m1_dat_i(m1_dat_i),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_o(s_dat_o), .s_sel(s_sel), .s_ack(s_ack), .s_err(s_err),
        .s_rty(s_rty), .s_dat_i(s_dat_i),
        .gnt(gnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 0; m0_dat_o = 0; m0_sel = 0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = 0; m1_dat_o = 0; m1_sel = 0;
        s_ack = 0; s_err = 0; s_rty = 0; s_dat_i = 0;
        #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_scyc", 32'(s_cyc), 32'h0);
        check("rst_sstb", 32'(s_stb), 32'h0);
        tick(); tick();
        rst = 1'b0;

        // single read by m0, ack two cycles after grant
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100; m0_sel = 4'hF;
        #1;
        check("a_gnt_lat", 32'(gnt), 32'h0);
        check("a_scyc_lat", 32'(s_cyc), 32'h0);
        tick();
        check("a_gnt", 32'(gnt), 32'h1);
        check("a_scyc", 32'(s_cyc), 32'h1);
        check("a_sstb", 32'(s_stb), 32'h1);
        check("a_sadr", s_adr, 32'h100);
        check("a_ack_early", 32'(m0_ack), 32'h0);
        tick();
        s_ack = 1; s_dat_i = 32'hDEADBEEF;
        #1;
        check("a_m0ack", 32'(m0_ack), 32'h1);
        check("a_m0dat", m0_dat_i, 32'hDEADBEEF);
        check("a_m1ack", 32'(m1_ack), 32'h0);
        check("a_m1dat", m1_dat_i, 32'h0);
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        tick();
        check("a_idle", 32'(gnt), 32'h0);

        // fresh reset, then simultaneous requests: m0, m1, m0, m1
        rst = 1; #1; tick(); rst = 0;
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'hA0;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'hB0;
        tick();
        check("b_g1", 32'(gnt), 32'h1);
        check("b_adr1", s_adr, 32'hA0);
        s_ack = 1; s_dat_i = 32'h1111;
        #1;
        check("b_m0ack", 32'(m0_ack), 32'h1);
        check("b_m1ack_lo", 32'(m1_ack), 32'h0);
        check("b_m0dat", m0_dat_i, 32'h1111);
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        #1;
        check("b_hold", 32'(gnt), 32'h1);
        tick();
        check("b_g2", 32'(gnt), 32'h2);
        check("b_adr2", s_adr, 32'hB0);
        m0_cyc = 1; m0_stb = 1;
        s_ack = 1;
        #1;
        check("b_m1ack", 32'(m1_ack), 32'h1);
        check("b_m0ack_lo", 32'(m0_ack), 32'h0);
        tick();
        s_ack = 0; m1_cyc = 0; m1_stb = 0;
        tick();
        check("b_g3", 32'(gnt), 32'h1);
        m1_cyc = 1; m1_stb = 1;
        s_ack = 1;
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        tick();
        check("b_g4", 32'(gnt), 32'h2);
        m1_cyc = 0; m1_stb = 0;
        tick();
        check("b_idle", 32'(gnt), 32'h0);

        // m0 4-beat burst, m1 must wait for m0.cyc to drop
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'hC0;
        tick();
        check("c_g0", 32'(gnt), 32'h1);
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'hD0;
        for (int i = 0; i < 4; i++) begin
            s_ack = 1;
            #1;
            check("c_m0ack", 32'(m0_ack), 32'h1);
            check("c_m1ack", 32'(m1_ack), 32'h0);
            tick();
            check("c_hold", 32'(gnt), 32'h1);
        end
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        tick();
        check("c_g1", 32'(gnt), 32'h2);
        check("c_adr", s_adr, 32'hD0);
        m1_cyc = 0; m1_stb = 0;
        tick();
        check("c_idle", 32'(gnt), 32'h0);

        // stray ack while idle is not forwarded
        s_ack = 1; s_err = 1;
        #1;
        check("d_m0ack", 32'(m0_ack), 32'h0);
        check("d_m1ack", 32'(m1_ack), 32'h0);
        check("d_m0err", 32'(m0_err), 32'h0);
        check("d_m1err", 32'(m1_err), 32'h0);
        check("d_scyc", 32'(s_cyc), 32'h0);
        s_ack = 0; s_err = 0;

        // asynchronous reset during an m1 burst
        m1_cyc = 1; m1_stb = 1;
        tick();
        check("e_g1", 32'(gnt), 32'h2);
        s_ack = 1;
        #3;
        rst = 1;
        #1;
        check("e_gnt", 32'(gnt), 32'h0);
        check("e_scyc", 32'(s_cyc), 32'h0);
        check("e_m1ack", 32'(m1_ack), 32'h0);
        check("e_m1err", 32'(m1_err), 32'h0);
        tick();
        rst = 0; s_ack = 0;
        m0_cyc = 1; m0_stb = 1;
        tick();
        check("e_tie", 32'(gnt), 32'h1);
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        tick(); tick();
        check("e_idle", 32'(gnt), 32'h0);

        // m1 write to a slave that never answers
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'hE0;
        tick();
        check("f_gnt", 32'(gnt), 32'h2);
        check("f_we", 32'(s_we), 32'h1);
`ifdef WB_ARB2_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            check("f_err_lo", 32'(m1_err), 32'h0);
            check("f_stb_hi", 32'(s_stb), 32'h1);
            tick();
        end
        check("f_err_hi", 32'(m1_err), 32'h1);
        check("f_stb_cut", 32'(s_stb), 32'h0);
        check("f_m0err", 32'(m0_err), 32'h0);
        tick();
        check("f_err_one", 32'(m1_err), 32'h0);
        check("f_stb_back", 32'(s_stb), 32'h1);
        check("f_cnt", 32'(dut.cnt), 32'h0);
`else
        for (int i = 0; i < 20; i++) begin
            check("f_err_lo", 32'(m1_err), 32'h0);
            check("f_hold", 32'(gnt), 32'h2);
            tick();
        end
`endif
        m1_cyc = 0; m1_stb = 0; m1_we = 0;
        tick();
        check("f_idle", 32'(gnt), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_arb2.md
WB_ARB2 -- requirements
Module: wb_arb2

Interface
REQ-001 SHALL have parameter: TIMEOUT, default 255, stalled-strobe cycles before a bus-error abort (8-bit range, 1..255).
REQ-002 SHALL have port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: m0  wishbone.slave  bundle  master 0 request port (priority on tie after reset).
REQ-005 SHALL have port: m1  wishbone.slave  bundle  master 1 request port.
REQ-006 SHALL have port: s  wishbone.master  bundle  shared downstream slave port.
REQ-007 SHALL have port: gnt  output  2  one-hot current grant (bit0=m0, bit1=m1), 2'b00 when idle.

Function
REQ-008 SHALL implement FSM states IDLE, GNT0, GNT1.
REQ-009 SHALL, in IDLE, move to GNT0/GNT1 on the next edge when only m0.cyc/only m1.cyc is high; no cyc -> stay IDLE.
REQ-010 SHALL, in IDLE with both cyc high, grant the master not granted last (round-robin pointer `last`).
REQ-011 SHALL hold GNTx while mx.cyc is high, regardless of the other master (no pre-emption, block transfers kept atomic).
REQ-012 SHALL, in GNTx with mx.cyc low, go directly to GNTy if my.cyc high, else IDLE; `last` updated to x on every grant exit.
REQ-013 SHALL give grant latency of exactly 1 cycle from cyc assertion in IDLE to s.cyc assertion.
REQ-014 SHALL route adr, dat_o, we, sel, stb, cyc of the granted master to s combinationally; in IDLE s.cyc=s.stb=0.
REQ-015 SHALL return s.ack, s.err, s.rty, s.dat_i to the granted master only; non-granted master sees ack=err=rty=0, dat_i=0.
REQ-016 SHALL ignore s.ack/err/rty arriving while IDLE (not forwarded).
REQ-017 SHALL drive gnt as registered one-hot of the FSM state.

Reset
REQ-018 SHALL, while rst high, force state IDLE, last=1 (m0 wins first tie), gnt=2'b00, timeout counter 0, s.cyc=s.stb=0.
REQ-019 SHALL, on rst asserted mid-transfer, abort immediately with no ack/err to either master; after release resume from IDLE.

Configuration
REQ-020 SHALL compile a stall watchdog when macro WB_ARB2_TIMEOUT_EN is defined.
REQ-021 SHALL, with WB_ARB2_TIMEOUT_EN: 8-bit counter increments each cycle with s.stb high and s.ack, s.err, s.rty all low; clears on any of ack/err/rty, on stb low, or grant change.
REQ-022 SHALL, with WB_ARB2_TIMEOUT_EN, when counter equals TIMEOUT: assert err to granted master for exactly one cycle, force s.stb=0 that cycle, clear counter.
REQ-023 SHALL, without WB_ARB2_TIMEOUT_EN: no counter; err only passed through from s; a stalled slave holds the grant indefinitely.

Verification
REQ-024 SHALL cover: m0 single read, s.ack after 2 cycles, s.dat_i=32'hDEADBEEF -> gnt=01 one cycle after m0.cyc, m0 sees ack and DEADBEEF, m1.ack=0.
REQ-025 SHALL cover: after reset m0.cyc and m1.cyc rise same cycle, each doing one access and then re-requesting -> grant order m0,m1,m0,m1, direct GNT0->GNT1 hand-over with no IDLE cycle.
REQ-026 SHALL cover: m0 holds cyc for 4-beat burst while m1 requests -> m1 stays ungranted until m0.cyc low, then gnt=10 next cycle.
REQ-027 SHALL cover (WB_ARB2_TIMEOUT_EN, TIMEOUT=16): m1 write, slave never acks -> m1.err high exactly one cycle, 16 cycles after first stalled stb, counter 0 afterwards.
REQ-028 SHALL cover: rst pulsed asynchronously (mid-cycle) during m1 burst -> gnt=00 and s.cyc=0 immediately, no ack/err; after release m0/m1 tie goes to m0.
REQ-029 SHALL cover: s.ack asserted while IDLE -> neither m0.ack nor m1.ack asserted.
